pipelined_adder_nbit: RTL and testbench
=======================================

# pipelined_adder_nbit

Parametrised, pipelined unsigned adder with a carry-in and a carry-out overflow flag. It splits a BIT_WIDTH-wide addition into NUM_STAGES equal chunks and registers the carry between them, so one addition is accepted per cycle. Results come out in order after a fixed latency. It serves datapaths where a full-width ripple carry chain does not meet timing, and a global hold input stalls the whole pipeline.

## Interface
- BIT_WIDTH, 32, operand/sum width; must be a multiple of NUM_STAGES
- NUM_STAGES, 4, pipeline depth; chunk width CW = BIT_WIDTH/NUM_STAGES; legal range 1..BIT_WIDTH
- clk  input  1  system clock, rising-edge active
- n_rst  input  1  asynchronous, active-low reset
- a  input  BIT_WIDTH  operand A (unsigned)
- b  input  BIT_WIDTH  operand B (unsigned)
- carry_in  input  1  carry into bit 0
- in_valid  input  1  a/b/carry_in are valid this cycle
- hold  input  1  stall: freeze every register in the block
- sum  output  BIT_WIDTH  registered result, a+b+carry_in mod 2^BIT_WIDTH
- overflow  output  1  registered carry out of bit BIT_WIDTH-1
- out_valid  output  1  sum/overflow carry a new result this cycle

## Operation
- Stage k (0..NUM_STAGES-1) adds chunk k of a and b, bits [k*CW +: CW], plus the registered carry from stage k-1. Stage 0 uses carry_in.
- Input skew: chunk k of a and b is delayed k register levels, so it meets its carry in the same cycle.
- Output deskew: the result chunk from stage k is delayed NUM_STAGES-1-k levels, so all chunks reach the output register together.
- A valid bit travels alongside each stage. The valid bit is set only for transactions sampled with in_valid=1 and hold=0.
- Data registers load every non-hold cycle, whether or not the data is valid.
- The sum/overflow output registers load only when the final-stage valid bit is 1. On bubbles they keep the last valid result.
- hold=1: every register, including valid bits and outputs, keeps its value. Input on that edge is ignored.
- NUM_STAGES=1: the block degenerates to a single registered adder with latency 1.
- Reset (n_rst=0, asynchronous): all pipeline registers, sum, overflow and out_valid go to 0 immediately. In-flight transactions are discarded and never appear after reset is released.
- There is no state machine. Control consists of the valid shift chain only.

## Timing
- Latency: a transaction is sampled on edge T with in_valid=1 and hold=0. out_valid=1 and the result appear after edge T+NUM_STAGES, counting only edges with hold=0.
- Throughput: one transaction per non-hold cycle. Output order equals input order.
- out_valid is high for exactly one cycle per transaction, unless hold extends it. Under hold it stays at its current value.
- Reset values: sum=0, overflow=0, out_valid=0.
- Simultaneous hold=1 and in_valid=1: the input is dropped. The upstream block must keep its data until hold falls.
- Critical path: one CW-bit add plus the carry register. There is no combinational path from any input to any output.

## Structure
- Shared package pipe_adder_pkg holds a function that checks BIT_WIDTH % NUM_STAGES == 0, used in an elaboration-time assertion. It also holds the chunk-width computation.
- Sub-module pipe_adder_stage (params CW): a registered CW-bit add with carry-in and carry-out and a hold enable. It is instantiated NUM_STAGES times in a generate loop.
- The skew and deskew register arrays live in the top module, built with generate loops.

## Test plan
Tests use BIT_WIDTH=32, NUM_STAGES=4 (CW=8).
- Reset: assert n_rst=0 mid-run -> sum=0, overflow=0, out_valid=0 immediately. No stale out_valid after release.
- Cross-chunk carry: a=0x000000FF, b=0x00000001, carry_in=0 -> 4 cycles later sum=0x00000100, overflow=0, out_valid=1 for 1 cycle.
- Full carry ripple: a=0xFFFFFFFF, b=0x00000000, carry_in=1 -> sum=0x00000000, overflow=1 at latency 4.
- Back-to-back: issue (1+2), (0x80000000+0x80000000), (0x12345678+0x11111111) on consecutive cycles -> results 0x3/ov0, 0x0/ov1, 0x23456789/ov0 on consecutive cycles. A bubble in the input gives one out_valid=0 cycle, and sum holds its last value.
- Hold: assert hold for 2 cycles with 3 transactions in flight -> every result arrives exactly 2 cycles later with correct values. An input presented during hold does not appear.
- Parameter sweep: NUM_STAGES=1 and NUM_STAGES=32 -> random operands match a+b+carry_in at latency 1 and 32 respectively.

Source files
------------

// File: rtl/pipelined_adder_nbit_pkg.sv
// Shared elaboration helpers for the pipelined adder: parameter legality
// check and the per-stage chunk width.
package pipe_adder_pkg;

  // Legal when the operand splits into 1..BIT_WIDTH equal chunks.
  function automatic bit width_ok(input int bw, input int ns);
    return (ns >= 1) && (ns <= bw) && ((bw % ns) == 0);
  endfunction

  // Chunk width per stage; guarded so an illegal NUM_STAGES=0 still elaborates
  // far enough to hit the legality check.
  function automatic int chunk_w(input int bw, input int ns);
    return (ns > 0) ? (bw / ns) : 1;
  endfunction

endpackage

// File: rtl/pipelined_adder_nbit_if.sv
// Operand/result bundle for the pipelined adder. The master drives operands
// and the stall, the slave (the adder) returns the registered result.
interface pipelined_adder_nbit_if #(
  parameter int BIT_WIDTH = 32
);
  logic [BIT_WIDTH-1:0] a;
  logic [BIT_WIDTH-1:0] b;
  logic                 carry_in;
  logic                 in_valid;
  logic                 hold;
  logic [BIT_WIDTH-1:0] sum;
  logic                 overflow;
  logic                 out_valid;

  modport master (
    output a, b, carry_in, in_valid, hold,
    input  sum, overflow, out_valid
  );

  modport slave (
    input  a, b, carry_in, in_valid, hold,
    output sum, overflow, out_valid
  );
endinterface

// File: rtl/pipelined_adder_nbit_stage.sv
// One pipeline stage: registered CW-bit add with carry in/out, plus the
// valid bit that travels with it. Hold freezes everything.
module pipe_adder_stage #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          i_hold,
  input  logic          i_vld,
  input  logic [CW-1:0] i_a,
  input  logic [CW-1:0] i_b,
  input  logic          i_cin,
  output logic [CW-1:0] o_sum,
  output logic          o_cout,
  output logic          o_vld
);

  logic [CW-1:0] r_sum;
  logic          r_cout;
  logic          r_vld;
  logic [CW:0]   w_add;

  assign w_add = {1'b0, i_a} + {1'b0, i_b} + {{CW{1'b0}}, i_cin};

  // Data loads on every non-hold cycle regardless of valid; valid rides along.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_vld  <= 1'b0;
    end else if (!i_hold) begin
      r_sum  <= w_add[CW-1:0];
      r_cout <= w_add[CW];
      r_vld  <= i_vld;
    end
  end

  assign o_sum  = r_sum;
  assign o_cout = r_cout;
  assign o_vld  = r_vld;

endmodule

// File: rtl/pipelined_adder_nbit.sv
// Pipelined unsigned adder: BIT_WIDTH split into NUM_STAGES chunks with the
// carry registered between them. Operand chunks are skewed in so each meets
// its carry, result chunks are deskewed out so they land together in the
// output register. Latency NUM_STAGES, one add per non-hold cycle.
module pipelined_adder_nbit
  import pipe_adder_pkg::*;
#(
  parameter int BIT_WIDTH  = 32,
  parameter int NUM_STAGES = 4
) (
  input logic                    clk,
  input logic                    n_rst,
  pipelined_adder_nbit_if.slave  bus
);

  localparam int CW = chunk_w(BIT_WIDTH, NUM_STAGES);

  if (!width_ok(BIT_WIDTH, NUM_STAGES)) begin : g_bad_params
    $error("pipelined_adder_nbit: BIT_WIDTH must be a multiple of NUM_STAGES, NUM_STAGES in 1..BIT_WIDTH");
  end

  logic [NUM_STAGES-1:0][CW-1:0] w_a_skw;
  logic [NUM_STAGES-1:0][CW-1:0] w_b_skw;
  logic [NUM_STAGES-1:0][CW-1:0] w_sum_stg;
  logic [NUM_STAGES-1:0][CW-1:0] w_sum_dsk;
  logic [NUM_STAGES:0]           w_carry;
  logic [NUM_STAGES:0]           w_vld_pipe;

  logic [BIT_WIDTH-1:0] r_sum;
  logic                 r_ovf;
  logic                 r_out_vld;

  assign w_carry[0]    = bus.carry_in;
  assign w_vld_pipe[0] = bus.in_valid;

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_lane
    localparam int SKW = k;
    localparam int DSK = NUM_STAGES - 1 - k;

    if (SKW == 0) begin : g_no_skw
      assign w_a_skw[k] = bus.a[k*CW +: CW];
      assign w_b_skw[k] = bus.b[k*CW +: CW];
    end else begin : g_skw
      logic [SKW-1:0][CW-1:0] r_a_dly;
      logic [SKW-1:0][CW-1:0] r_b_dly;

      // Delay chunk k by k levels so it reaches stage k with its carry.
      always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
          r_a_dly <= '0;
          r_b_dly <= '0;
        end else if (!bus.hold) begin
          r_a_dly[0] <= bus.a[k*CW +: CW];
          r_b_dly[0] <= bus.b[k*CW +: CW];
          for (int j = 1; j < SKW; j++) begin
            r_a_dly[j] <= r_a_dly[j-1];
            r_b_dly[j] <= r_b_dly[j-1];
          end
        end
      end

      assign w_a_skw[k] = r_a_dly[SKW-1];
      assign w_b_skw[k] = r_b_dly[SKW-1];
    end

    pipe_adder_stage #(.CW(CW)) u_stage (
      .clk    (clk),
      .n_rst  (n_rst),
      .i_hold (bus.hold),
      .i_vld  (w_vld_pipe[k]),
      .i_a    (w_a_skw[k]),
      .i_b    (w_b_skw[k]),
      .i_cin  (w_carry[k]),
      .o_sum  (w_sum_stg[k]),
      .o_cout (w_carry[k+1]),
      .o_vld  (w_vld_pipe[k+1])
    );

    if (DSK == 0) begin : g_no_dsk
      assign w_sum_dsk[k] = w_sum_stg[k];
    end else begin : g_dsk
      logic [DSK-1:0][CW-1:0] r_s_dly;

      // Hold early result chunks back until the last stage catches up.
      always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
          r_s_dly <= '0;
        end else if (!bus.hold) begin
          r_s_dly[0] <= w_sum_stg[k];
          for (int j = 1; j < DSK; j++) begin
            r_s_dly[j] <= r_s_dly[j-1];
          end
        end
      end

      assign w_sum_dsk[k] = r_s_dly[DSK-1];
    end
  end

  // Output register: capture only real results, keep the last one on bubbles.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_sum     <= '0;
      r_ovf     <= 1'b0;
      r_out_vld <= 1'b0;
    end else if (!bus.hold) begin
      r_out_vld <= w_vld_pipe[NUM_STAGES];
      if (w_vld_pipe[NUM_STAGES]) begin
        r_sum <= w_sum_dsk;
        r_ovf <= w_carry[NUM_STAGES];
      end
    end
  end

  assign bus.sum       = r_sum;
  assign bus.overflow  = r_ovf;
  assign bus.out_valid = r_out_vld;

endmodule

// File: tb/tb_pipelined_adder_nbit.sv
// Directed bench for the pipelined adder (32-bit, 4 stages) plus random
// sweeps of the 1-stage and 32-stage builds against a latency-tagged queue.
module tb_pipelined_adder_nbit;

  logic clk;
  logic n_rst;
  int   n_vec;
  int   n_err;
  int   cyc;

  pipelined_adder_nbit_if #(.BIT_WIDTH(32)) bus4  ();
  pipelined_adder_nbit_if #(.BIT_WIDTH(32)) bus1  ();
  pipelined_adder_nbit_if #(.BIT_WIDTH(32)) bus32 ();

  pipelined_adder_nbit #(.BIT_WIDTH(32), .NUM_STAGES(4))  dut4  (.clk(clk), .n_rst(n_rst), .bus(bus4));
  pipelined_adder_nbit #(.BIT_WIDTH(32), .NUM_STAGES(1))  dut1  (.clk(clk), .n_rst(n_rst), .bus(bus1));
  pipelined_adder_nbit #(.BIT_WIDTH(32), .NUM_STAGES(32)) dut32 (.clk(clk), .n_rst(n_rst), .bus(bus32));

  typedef struct {
    logic [31:0] s;
    logic        o;
    int          c;
  } exp_t;

  exp_t q1[$];
  exp_t q32[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [31:0] s, input logic o, input logic v);
    chk({tag, "_sum"}, {1'b0, bus4.sum}, {1'b0, s});
    chk({tag, "_ovf"}, {32'd0, bus4.overflow}, {32'd0, o});
    chk({tag, "_vld"}, {32'd0, bus4.out_valid}, {32'd0, v});
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic c, input logic v);
    bus4.a = a;  bus4.b = b;  bus4.carry_in = c;  bus4.in_valid = v;
    bus1.a = a;  bus1.b = b;  bus1.carry_in = c;  bus1.in_valid = v;
    bus32.a = a; bus32.b = b; bus32.carry_in = c; bus32.in_valid = v;
  endtask

  task automatic set_hold(input logic h);
    bus4.hold = h; bus1.hold = h; bus32.hold = h;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rc;
    logic        sent;
    logic        ev;
    exp_t        e;

    n_vec = 0; n_err = 0; cyc = 0;
    n_rst = 1'b0;
    drive(32'd0, 32'd0, 1'b0, 1'b0);
    set_hold(1'b0);
    step(); step();
    chk4("por", 32'd0, 1'b0, 1'b0);
    n_rst = 1'b1;
    step();

    // cross-chunk carry, latency 4, single-cycle valid
    drive(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b1); step();
    drive(32'd0, 32'd0, 1'b0, 1'b0);
    step(); step(); step();
    chk("xc_early_vld", {32'd0, bus4.out_valid}, 33'd0);
    step();
    chk4("xc", 32'h0000_0100, 1'b0, 1'b1);
    step();
    chk4("xc_after", 32'h0000_0100, 1'b0, 1'b0);

    // full ripple via carry_in
    drive(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1); step();
    drive(32'd0, 32'd0, 1'b0, 1'b0);
    step(); step(); step();
    chk("rip_early_vld", {32'd0, bus4.out_valid}, 33'd0);
    step();
    chk4("rip", 32'h0000_0000, 1'b1, 1'b1);
    step();

    // back-to-back, then a bubble, then one more
    drive(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b1); step();
    drive(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1); step();
    drive(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1); step();
    drive(32'd0, 32'd0, 1'b0, 1'b0);                 step();
    drive(32'h0000_0005, 32'h0000_0006, 1'b1, 1'b1); step();
    chk4("b2b0", 32'h0000_0003, 1'b0, 1'b1);
    drive(32'd0, 32'd0, 1'b0, 1'b0);
    step(); chk4("b2b1", 32'h0000_0000, 1'b1, 1'b1);
    step(); chk4("b2b2", 32'h2345_6789, 1'b0, 1'b1);
    step(); chk4("bubble", 32'h2345_6789, 1'b0, 1'b0);
    step(); chk4("b2b3", 32'h0000_000C, 1'b0, 1'b1);
    step(); chk4("b2b_idle", 32'h0000_000C, 1'b0, 1'b0);

    // hold for 2 edges with three in flight; input during hold is dropped
    drive(32'h0000_000A, 32'h0000_000B, 1'b0, 1'b1); step();
    drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1); step();
    drive(32'h00FF_00FF, 32'h0F0F_0F0F, 1'b0, 1'b1); step();
    set_hold(1'b1);
    drive(32'h0000_0007, 32'h0000_0007, 1'b0, 1'b1);
    step(); step();
    chk4("hold_frozen", 32'h0000_000C, 1'b0, 1'b0);
    set_hold(1'b0);
    drive(32'd0, 32'd0, 1'b0, 1'b0);
    step(); chk("hold_not_yet", {32'd0, bus4.out_valid}, 33'd0);
    step(); chk4("hold0", 32'h0000_0015, 1'b0, 1'b1);
    step(); chk4("hold1", 32'hFFFF_FFFF, 1'b1, 1'b1);
    step(); chk4("hold2", 32'h100E_100E, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(); chk4("hold_drop", 32'h100E_100E, 1'b0, 1'b0);
    end

    // mid-run async reset while a result is showing and another is in flight
    drive(32'h0000_0011, 32'h0000_0022, 1'b0, 1'b1); step();
    drive(32'h0000_0040, 32'h0000_0002, 1'b0, 1'b1); step();
    drive(32'd0, 32'd0, 1'b0, 1'b0);
    step(); step(); step();
    chk4("pre_rst", 32'h0000_0033, 1'b0, 1'b1);
    #2 n_rst = 1'b0;
    #1 chk4("async_rst", 32'd0, 1'b0, 1'b0);
    step();
    n_rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(); chk4("post_rst", 32'd0, 1'b0, 1'b0);
    end

    // random sweep of the 1-stage and 32-stage builds
    for (int i = 0; i < 100; i++) begin
      sent = 1'b0;
      if (i < 60 && $urandom_range(3) != 0) begin
        ra = $urandom; rb = $urandom; rc = 1'($urandom_range(1));
        drive(ra, rb, rc, 1'b1);
        sent = 1'b1;
      end else begin
        drive(32'd0, 32'd0, 1'b0, 1'b0);
      end
      step();
      if (sent) begin
        {e.o, e.s} = {1'b0, ra} + {1'b0, rb} + 33'(rc);
        e.c = cyc;
        q1.push_back(e);
        q32.push_back(e);
      end
      ev = (q1.size() > 0) && (q1[0].c + 1 == cyc);
      chk("sw1_vld", {32'd0, bus1.out_valid}, {32'd0, ev});
      if (ev) begin
        e = q1.pop_front();
        chk("sw1_sum", {1'b0, bus1.sum}, {1'b0, e.s});
        chk("sw1_ovf", {32'd0, bus1.overflow}, {32'd0, e.o});
      end
      ev = (q32.size() > 0) && (q32[0].c + 32 == cyc);
      chk("sw32_vld", {32'd0, bus32.out_valid}, {32'd0, ev});
      if (ev) begin
        e = q32.pop_front();
        chk("sw32_sum", {1'b0, bus32.sum}, {1'b0, e.s});
        chk("sw32_ovf", {32'd0, bus32.overflow}, {32'd0, e.o});
      end
    end
    chk("sw1_drained", 33'(q1.size()), 33'd0);
    chk("sw32_drained", 33'(q32.size()), 33'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
